// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Owns the PC register and issues instruction-memory
// requests. Buffers a response that arrives while IF/ID is stalled, and holds
// the IF/ID pipeline register. Control-unit flow signals (pcSel, pcStall,
// ifidStall, instNop) are applied in the cycle they are presented.
//
// Ports
//   clk, reset      : single clock, synchronous active-high reset
//   pcSel           : next-PC select (0 PC+4, 1 branchTarget, 2 jalrTarget,
//                     3 RESET_PC)
//   branchTarget    : branch/JAL target from ID
//   jalrTarget      : JALR target from ID (bit 0 cleared here)
//   pcStall         : hold PC and suppress any redirect this cycle
//   ifidStall       : hold IF/ID contents
//   instNop         : the instruction entering IF/ID becomes NOP_INST
//   imemReq/Addr    : request strobe and word-aligned address
//   imemValid/Data  : response, at least one cycle after imemReq
//   dInst/dPc/dPc4  : IF/ID instruction, PC and PC+4
//   dValid          : IF/ID holds a real instruction
//   fetchBusy       : no instruction is available to IF/ID this cycle
//   dbgState        : current FSM state (0 FETCH, 1 WAIT, 2 HAVE)
//
// Memory handshake: imemReq is a one-cycle strobe raised only in FETCH, so at
// most one request is outstanding. The memory answers with exactly one
// imemValid pulse, carrying imemData, one or more cycles later. There is no
// back-pressure toward memory: a response is always consumed in the cycle it
// arrives, either into IF/ID, into the local buffer, or dropped as stale.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      pcSel,
  input  logic [XLEN-1:0] branchTarget,
  input  logic [XLEN-1:0] jalrTarget,
  input  logic            pcStall,
  input  logic            ifidStall,
  input  logic            instNop,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemValid,
  input  logic [31:0]     imemData,
  output logic [31:0]     dInst,
  output logic [XLEN-1:0] dPc,
  output logic [XLEN-1:0] dPc4,
  output logic            dValid,
  output logic            fetchBusy,
  output logic [1:0]      dbgState
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HAVE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            discard, discard_nxt;
  logic [31:0]     ibuf, ibuf_nxt;
  logic [31:0]     dinst_nxt;
  logic [XLEN-1:0] dpc_nxt, dpc4_nxt;
  logic            dvalid_nxt;

  logic            resp_ok;
  logic            resp_stale;
  logic            avail;
  logic [31:0]     inst;
  logic            stall;
  logic            fire;
  logic            redirect;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jalr_aligned;
  logic [XLEN-1:0] sel_pc;

  // Datapath and availability.
  always_comb begin
    pc_plus4     = pc + XLEN'(4);
    jalr_aligned = jalrTarget & ~{{(XLEN-1){1'b0}}, 1'b1};
    case (pcSel)
      2'd0:    sel_pc = pc_plus4;
      2'd1:    sel_pc = branchTarget;
      2'd2:    sel_pc = jalr_aligned;
      default: sel_pc = RESET_PC;
    endcase

    // imemValid is meaningless while reset is asserted.
    resp_ok    = !reset && (state == S_WAIT) && imemValid && !discard;
    resp_stale = !reset && (state == S_WAIT) && imemValid && discard;
    avail      = resp_ok || (!reset && (state == S_HAVE));
    inst       = (state == S_HAVE) ? ibuf : imemData;

    // pcStall alone still freezes the whole stage, so it counts as a stall.
    stall    = ifidStall || pcStall;
    fire     = avail && !stall;
    redirect = (pcSel != 2'd0) && !pcStall;

    imemReq   = !reset && (state == S_FETCH);
    imemAddr  = {pc[XLEN-1:2], 2'b00};
    fetchBusy = !avail;
    dbgState  = state;
  end

  // Next-state logic.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    ibuf_nxt    = ibuf;
    dinst_nxt   = dInst;
    dpc_nxt     = dPc;
    dpc4_nxt    = dPc4;
    dvalid_nxt  = dValid;

    if (fire) begin
      dinst_nxt   = instNop ? NOP_INST : inst;
      dpc_nxt     = pc;
      dpc4_nxt    = pc_plus4;
      dvalid_nxt  = !instNop;
      pc_nxt      = sel_pc;
      state_nxt   = S_FETCH;
      discard_nxt = 1'b0;
    end else begin
      // Nothing to hand over and IF/ID free: push a bubble, keep dPc/dPc4.
      if (!avail && !ifidStall) begin
        dinst_nxt  = NOP_INST;
        dvalid_nxt = 1'b0;
      end

      if (redirect) begin
        pc_nxt = sel_pc;
        case (state)
          S_FETCH: begin
            // The request leaving this cycle still carries the old pc, so
            // its answer must be thrown away.
            state_nxt   = S_WAIT;
            discard_nxt = 1'b1;
          end
          S_WAIT: begin
            if (imemValid) begin
              // Response for the old path arrives now: drop it and refetch.
              state_nxt   = S_FETCH;
              discard_nxt = 1'b0;
            end else begin
              discard_nxt = 1'b1;
            end
          end
          default: begin
            state_nxt = S_FETCH;
          end
        endcase
      end else if (avail) begin
        if (state == S_WAIT) begin
          ibuf_nxt = imemData;
        end
        state_nxt = S_HAVE;
      end else if (resp_stale) begin
        state_nxt   = S_FETCH;
        discard_nxt = 1'b0;
      end else if (state == S_FETCH) begin
        state_nxt = S_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      discard <= 1'b0;
      ibuf    <= NOP_INST;
      dInst   <= NOP_INST;
      dPc     <= '0;
      dPc4    <= '0;
      dValid  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      discard <= discard_nxt;
      ibuf    <= ibuf_nxt;
      dInst   <= dinst_nxt;
      dPc     <= dpc_nxt;
      dPc4    <= dpc4_nxt;
      dValid  <= dvalid_nxt;
    end
  end

endmodule
